// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode encodings, FSM states,
// and the opcode decode helpers used by the stage controller.
package alu_pkg;

  localparam int unsigned ALU_DATA_WIDTH    = 8;
  localparam int unsigned ALU_OPCODE_LENGTH = 4;
  localparam int unsigned VECTOR_LENGTH     = ALU_OPCODE_LENGTH + 2 * ALU_DATA_WIDTH;

  typedef logic [ALU_OPCODE_LENGTH-1:0] opcode_t;

  localparam opcode_t OP_NOP       = 4'b0000;
  localparam opcode_t OP_ADD       = 4'b0001;
  localparam opcode_t OP_SUB       = 4'b0010;
  localparam opcode_t OP_MULT      = 4'b0011;
  localparam opcode_t OP_DIVIDE    = 4'b0100;
  localparam opcode_t OP_AND       = 4'b0110;
  localparam opcode_t OP_OR        = 4'b0111;
  localparam opcode_t OP_ZERO_TEST = 4'b1001;
  localparam opcode_t OP_GT        = 4'b1010;
  localparam opcode_t OP_EQ        = 4'b1011;
  localparam opcode_t OP_LT        = 4'b1100;
  localparam opcode_t OP_LDI       = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // MULT and DIVIDE use the long ALU latency.
  function automatic logic is_muldiv(input opcode_t op);
    return (op == OP_MULT) || (op == OP_DIVIDE);
  endfunction

  // Ops whose result lands in rd; compare/test ops only touch the flags.
  function automatic logic writes_rd(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MULT) ||
           (op == OP_DIVIDE) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // Unassigned encodings: consumed without retiring.
  function automatic logic is_illegal(input opcode_t op);
    return (op == 4'b0101) || (op == 4'b1000) || (op == 4'b1101) || (op == 4'b1110);
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake plus ALU vector/result bus of the issue stage.
// slave: the issue stage; master: the instruction source and the ALU side.
interface alu_issue_stage_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned OPCODE_LENGTH = 4
);

  logic [15:0]                           instr_in;
  logic                                  instr_valid;
  logic                                  instr_ready;
  logic [OPCODE_LENGTH+2*DATA_WIDTH-1:0] opcode_inputs;
  logic [DATA_WIDTH-1:0]                 final_output;
  logic                                  carry_output;
  logic                                  zero_flag;

  modport slave (
    input  instr_in, instr_valid, final_output, carry_output, zero_flag,
    output instr_ready, opcode_inputs
  );

  modport master (
    output instr_in, instr_valid, final_output, carry_output, zero_flag,
    input  instr_ready, opcode_inputs
  );

endinterface

// File: rtl/alu_regfile.sv
// 8x8 register file: two combinational operand read ports, one debug read
// port, one synchronous write port, asynchronous clear.
module alu_regfile #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic [REG_ADDR_W-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  input  logic [REG_ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_WIDTH-1:0] dbg_data_o
);

  localparam int unsigned NREGS = 1 << REG_ADDR_W;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];

  // Register storage: cleared on reset, single write per cycle.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: accepts one instruction at a time, reads operands, holds
// the packed ALU opcode vector for the op latency, then writes back result
// and flags. Optional macro ALU_ISSUE_PERF_EN adds retire/busy counters.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned OPCODE_LENGTH  = 4,
  parameter int unsigned REG_ADDR_W     = 3,
  parameter int unsigned ALU_LATENCY    = 2,
  parameter int unsigned MULDIV_LATENCY = 6
) (
  input  logic                  clk,
  input  logic                  reset_in,
  alu_issue_stage_if.slave      bus,
  output logic                  flag_carry,
  output logic                  flag_zero,
  output logic                  retire,
  output logic                  illegal_op,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [15:0]           perf_retired,
  output logic [15:0]           perf_busy
`endif
);

  localparam int unsigned VEC_W   = OPCODE_LENGTH + 2 * DATA_WIDTH;
  localparam int unsigned MAX_LAT = (ALU_LATENCY > MULDIV_LATENCY) ? ALU_LATENCY : MULDIV_LATENCY;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [VEC_W-1:0]      vec_q, vec_d;
  opcode_t               op_q, op_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  retire_q, retire_d;
  logic                  illegal_q, illegal_d;
  logic                  flag_c_q, flag_c_d;
  logic                  flag_z_q, flag_z_d;

  opcode_t               instr_op;
  logic [REG_ADDR_W-1:0] instr_rd, instr_rs1, instr_rs2;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] rs1_data, rs2_data;
  logic                  accept;

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  assign instr_op  = bus.instr_in[15:12];
  assign instr_rd  = REG_ADDR_W'(bus.instr_in[11:9]);
  assign instr_rs1 = REG_ADDR_W'(bus.instr_in[8:6]);
  assign instr_rs2 = REG_ADDR_W'(bus.instr_in[5:3]);
  assign imm       = DATA_WIDTH'(bus.instr_in[7:0]);

  assign bus.instr_ready   = (state_q == IDLE) && !reset_in;
  assign accept            = bus.instr_valid && bus.instr_ready;
  assign bus.opcode_inputs = vec_q;

  assign flag_carry = flag_c_q;
  assign flag_zero  = flag_z_q;
  assign retire     = retire_q;
  assign illegal_op = illegal_q;

  alu_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk        (clk),
    .reset_in   (reset_in),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .raddr_a_i  (instr_rs1),
    .rdata_a_o  (rs1_data),
    .raddr_b_i  (instr_rs2),
    .rdata_b_o  (rs2_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      vec_q     <= '0;
      op_q      <= OP_NOP;
      rd_q      <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vec_q     <= vec_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
    end
  end

  // Next-state decode: IDLE accepts and dispatches, EXEC counts down the
  // latency and writes back on the final count. The single regfile write port
  // is shared: LDI writes on accept, ALU ops on completion, never together.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    op_d      = op_q;
    rd_d      = rd_q;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_illegal(instr_op)) begin
            illegal_d = 1'b1;
          end else if (instr_op == OP_NOP) begin
            retire_d = 1'b1;
          end else if (instr_op == OP_LDI) begin
            rf_we    = 1'b1;
            rf_waddr = instr_rd;
            rf_wdata = imm;
            retire_d = 1'b1;
          end else begin
            vec_d   = {OPCODE_LENGTH'(instr_op), rs1_data, rs2_data};
            op_d    = instr_op;
            rd_d    = instr_rd;
            cnt_d   = is_muldiv(instr_op) ? CNT_W'(MULDIV_LATENCY - 1)
                                          : CNT_W'(ALU_LATENCY - 1);
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          if (writes_rd(op_q)) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = bus.final_output;
          end
          flag_c_d = bus.carry_output;
          flag_z_d = bus.zero_flag;
          retire_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] perf_retired_q;
  logic [15:0] perf_busy_q;

  // Retire count wraps; busy-cycle count saturates.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      perf_retired_q <= '0;
      perf_busy_q    <= '0;
    end else begin
      if (retire_q) begin
        perf_retired_q <= perf_retired_q + 16'd1;
      end
      if ((state_q == EXEC) && (perf_busy_q != '1)) begin
        perf_busy_q <= perf_busy_q + 16'd1;
      end
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_busy    = perf_busy_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage. The bench plays the ALU: it drives
// junk on the result bus except in the single cycle before the expected
// sampling edge. Retirements are checked against a scoreboard queue.
module tb_alu_issue_stage;
  import alu_pkg::*;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] val;
    logic       c;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_in;
  logic       flag_carry, flag_zero, retire, illegal_op;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;
`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] perf_retired, perf_busy;
`endif

  exp_t        sb[$];
  logic [7:0]  mregs [8];
  logic        mc, mz;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.DATA_WIDTH(8), .OPCODE_LENGTH(4)) bus ();

  alu_issue_stage #(
    .DATA_WIDTH     (8),
    .OPCODE_LENGTH  (4),
    .REG_ADDR_W     (3),
    .ALU_LATENCY    (2),
    .MULDIV_LATENCY (6)
  ) dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .bus        (bus),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero),
    .retire     (retire),
    .illegal_op (illegal_op),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_retired (perf_retired),
    .perf_busy    (perf_busy)
`endif
  );

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] mk_ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {4'hF, rd, 1'b0, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic sb_pop(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    if (ok) e = sb.pop_front();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    mc = 1'b0;
    mz = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset_in = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_in = '0;
    bus.final_output = 8'h00;
    bus.carry_output = 1'b0;
    bus.zero_flag = 1'b0;
    dbg_addr = 3'd0;
    model_reset();
    tick(); tick();
    n_tests++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.instr_ready); end
    n_tests++; if (retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire got %b want 0", retire); end
    n_tests++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal_op); end
    n_tests++; if (bus.opcode_inputs !== 20'h0) begin n_fail++; $display("FAIL reset_vec got %h want 00000", bus.opcode_inputs); end
    n_tests++; if ({flag_carry, flag_zero} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {flag_carry, flag_zero}); end
    reset_in = 1'b0;
    tick();
    n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", bus.instr_ready); end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_reg R%0d got %h want 00", i, v); end
    end
  endtask

  task automatic ldi(input logic [2:0] rd, input logic [7:0] imm);
    exp_t e; bit ok; logic [7:0] v;
    mregs[rd] = imm;
    sb.push_back('{rd: rd, val: imm, c: mc, z: mz});
    bus.instr_in = mk_ldi(rd, imm);
    bus.instr_valid = 1'b1;
    n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL ldi_ready got %b want 1", bus.instr_ready); end
    tick();
    bus.instr_valid = 1'b0;
    n_tests++; if (retire !== 1'b1) begin n_fail++; $display("FAIL ldi_retire R%0d got %b want 1", rd, retire); end
    sb_pop(e, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ldi_sb got empty want entry"); end
    else begin
      read_reg(e.rd, v);
      n_tests++; if (v !== e.val) begin n_fail++; $display("FAIL ldi_reg R%0d got %h want %h", e.rd, v, e.val); end
    end
    tick();
  endtask

  // One ALU op: result bus carries the real answer only in the last EXEC cycle.
  task automatic run_alu(input string tag, input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2, input int lat,
                         input logic [7:0] res, input logic c, input logic z, input bit wr);
    exp_t e; bit ok; logic [7:0] v; logic [19:0] xvec;
    xvec = {op, mregs[rs1], mregs[rs2]};
    if (wr) mregs[rd] = res;
    mc = c; mz = z;
    sb.push_back('{rd: rd, val: mregs[rd], c: c, z: z});
    bus.instr_in = mk(op, rd, rs1, rs2);
    bus.instr_valid = 1'b1;
    bus.final_output = ~res; bus.carry_output = ~c; bus.zero_flag = ~z;
    n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL %s accept_ready got %b want 1", tag, bus.instr_ready); end
    tick();
    bus.instr_valid = 1'b0;
    bus.instr_in = '0;
    for (int k = 1; k <= lat; k++) begin
      n_tests++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL %s exec_ready cyc %0d got %b want 0", tag, k, bus.instr_ready); end
      n_tests++; if (bus.opcode_inputs !== xvec) begin n_fail++; $display("FAIL %s exec_vec cyc %0d got %h want %h", tag, k, bus.opcode_inputs, xvec); end
      n_tests++; if (retire !== 1'b0) begin n_fail++; $display("FAIL %s early_retire cyc %0d got %b want 0", tag, k, retire); end
      if (k == lat) begin bus.final_output = res; bus.carry_output = c; bus.zero_flag = z; end
      tick();
    end
    bus.final_output = ~res; bus.carry_output = ~c; bus.zero_flag = ~z;
    n_tests++; if (retire !== 1'b1) begin n_fail++; $display("FAIL %s retire got %b want 1", tag, retire); end
    n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL %s done_ready got %b want 1", tag, bus.instr_ready); end
    n_tests++; if (bus.opcode_inputs !== xvec) begin n_fail++; $display("FAIL %s vec_hold got %h want %h", tag, bus.opcode_inputs, xvec); end
    sb_pop(e, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL %s sb got empty want entry", tag); end
    else begin
      read_reg(e.rd, v);
      n_tests++; if (v !== e.val) begin n_fail++; $display("FAIL %s reg R%0d got %h want %h", tag, e.rd, v, e.val); end
      n_tests++; if ({flag_carry, flag_zero} !== {e.c, e.z}) begin n_fail++; $display("FAIL %s flags got %b want %b", tag, {flag_carry, flag_zero}, {e.c, e.z}); end
    end
    tick();
    n_tests++; if (retire !== 1'b0) begin n_fail++; $display("FAIL %s retire_len got %b want 0", tag, retire); end
  endtask

  task automatic test_add();
    ldi(3'd1, 8'hFF);
    ldi(3'd2, 8'h01);
    run_alu("add", OP_ADD, 3'd3, 3'd1, 3'd2, 2, 8'h00, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_compare_and_logic();
    ldi(3'd4, 8'h05);
    ldi(3'd5, 8'h09);
    run_alu("lt",  OP_LT,  3'd4, 3'd4, 3'd5, 2, 8'h01, 1'b0, 1'b0, 1'b0);
    run_alu("sub", OP_SUB, 3'd7, 3'd4, 3'd5, 2, 8'hFC, 1'b1, 1'b0, 1'b1);
    run_alu("or",  OP_OR,  3'd0, 3'd4, 3'd5, 2, 8'h0D, 1'b0, 1'b0, 1'b1);
    run_alu("gt",  OP_GT,  3'd5, 3'd4, 3'd5, 2, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_mult_stall();
    exp_t e; bit ok; logic [7:0] v; logic [19:0] xvec; int low;
    xvec = {OP_MULT, mregs[1], mregs[2]};
    mregs[6] = 8'hFF; mc = 1'b0; mz = 1'b0;
    sb.push_back('{rd: 3'd6, val: 8'hFF, c: 1'b0, z: 1'b0});
    bus.instr_in = mk(OP_MULT, 3'd6, 3'd1, 3'd2);
    bus.instr_valid = 1'b1;
    bus.final_output = 8'h3C; bus.carry_output = 1'b1; bus.zero_flag = 1'b1;
    tick();
    bus.instr_in = mk_ldi(3'd7, 8'h5A);
    low = 0;
    for (int k = 1; k <= 6; k++) begin
      if (bus.instr_ready === 1'b0) low++;
      n_tests++; if (bus.opcode_inputs !== xvec) begin n_fail++; $display("FAIL mult_vec cyc %0d got %h want %h", k, bus.opcode_inputs, xvec); end
      read_reg(3'd7, v);
      n_tests++; if (v !== mregs[7]) begin n_fail++; $display("FAIL mult_stall_ldi cyc %0d R7 got %h want %h", k, v, mregs[7]); end
      if (k == 6) begin bus.final_output = 8'hFF; bus.carry_output = 1'b0; bus.zero_flag = 1'b0; end
      #3;
      tick();
    end
    bus.final_output = 8'h3C; bus.carry_output = 1'b1; bus.zero_flag = 1'b1;
    n_tests++; if (low != 6) begin n_fail++; $display("FAIL mult_ready_low got %0d want 6", low); end
    n_tests++; if (retire !== 1'b1) begin n_fail++; $display("FAIL mult_retire got %b want 1", retire); end
    n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL mult_done_ready got %b want 1", bus.instr_ready); end
    sb_pop(e, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL mult_sb got empty want entry"); end
    else begin
      read_reg(e.rd, v);
      n_tests++; if (v !== e.val) begin n_fail++; $display("FAIL mult_reg R6 got %h want %h", v, e.val); end
      n_tests++; if ({flag_carry, flag_zero} !== {e.c, e.z}) begin n_fail++; $display("FAIL mult_flags got %b want %b", {flag_carry, flag_zero}, {e.c, e.z}); end
    end
    mregs[7] = 8'h5A;
    sb.push_back('{rd: 3'd7, val: 8'h5A, c: mc, z: mz});
    tick();
    bus.instr_valid = 1'b0;
    n_tests++; if (retire !== 1'b1) begin n_fail++; $display("FAIL held_ldi_retire got %b want 1", retire); end
    sb_pop(e, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL held_ldi_sb got empty want entry"); end
    else begin
      read_reg(e.rd, v);
      n_tests++; if (v !== e.val) begin n_fail++; $display("FAIL held_ldi_reg R7 got %h want %h", v, e.val); end
    end
    tick();
    n_tests++; if (retire !== 1'b0) begin n_fail++; $display("FAIL held_ldi_retire_len got %b want 0", retire); end
  endtask

  task automatic test_nop();
    bus.instr_in = mk(OP_NOP, 3'd2, 3'd1, 3'd1);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    n_tests++; if (retire !== 1'b1) begin n_fail++; $display("FAIL nop_retire got %b want 1", retire); end
    n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL nop_ready got %b want 1", bus.instr_ready); end
    tick();
    n_tests++; if (retire !== 1'b0) begin n_fail++; $display("FAIL nop_retire_len got %b want 0", retire); end
  endtask

  task automatic test_illegal();
    logic [3:0] ops [4];
    logic [7:0] v;
    ops[0] = 4'b0101; ops[1] = 4'b1000; ops[2] = 4'b1101; ops[3] = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      bus.instr_in = mk(ops[i], 3'd3, 3'd1, 3'd2);
      bus.instr_valid = 1'b1;
      bus.final_output = 8'h77; bus.carry_output = ~mc; bus.zero_flag = ~mz;
      tick();
      bus.instr_valid = 1'b0;
      n_tests++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse op %b got %b want 1", ops[i], illegal_op); end
      n_tests++; if (retire !== 1'b0) begin n_fail++; $display("FAIL illegal_retire op %b got %b want 0", ops[i], retire); end
      n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready op %b got %b want 1", ops[i], bus.instr_ready); end
      tick();
      n_tests++; if ({illegal_op, retire} !== 2'b00) begin n_fail++; $display("FAIL illegal_after op %b got %b want 00", ops[i], {illegal_op, retire}); end
    end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      n_tests++; if (v !== mregs[i]) begin n_fail++; $display("FAIL illegal_reg R%0d got %h want %h", i, v, mregs[i]); end
    end
    n_tests++; if ({flag_carry, flag_zero} !== {mc, mz}) begin n_fail++; $display("FAIL illegal_flags got %b want %b", {flag_carry, flag_zero}, {mc, mz}); end
  endtask

  task automatic test_reset_mid_exec();
    logic [7:0] v;
    run_alu("pre_abort_add", OP_ADD, 3'd3, 3'd1, 3'd2, 2, 8'h00, 1'b1, 1'b1, 1'b1);
    bus.instr_in = mk(OP_MULT, 3'd6, 3'd1, 3'd2);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    bus.final_output = 8'h99; bus.carry_output = 1'b1; bus.zero_flag = 1'b1;
    tick();
    reset_in = 1'b1;
    #1;
    n_tests++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready got %b want 0", bus.instr_ready); end
    n_tests++; if (bus.opcode_inputs !== 20'h0) begin n_fail++; $display("FAIL abort_vec got %h want 00000", bus.opcode_inputs); end
    n_tests++; if ({flag_carry, flag_zero} !== 2'b00) begin n_fail++; $display("FAIL abort_flags got %b want 00", {flag_carry, flag_zero}); end
    model_reset();
    tick();
    reset_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL abort_reg R%0d got %h want 00", i, v); end
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      n_tests++; if ({retire, bus.instr_ready} !== 2'b01) begin n_fail++; $display("FAIL abort_quiet cyc %0d retire/ready got %b want 01", k, {retire, bus.instr_ready}); end
      tick();
    end
    n_tests++; if ({flag_carry, flag_zero} !== 2'b00) begin n_fail++; $display("FAIL abort_flags_late got %b want 00", {flag_carry, flag_zero}); end
    ldi(3'd1, 8'hAA);
  endtask

  task automatic test_back_to_back();
    exp_t e; bit ok; logic [7:0] v;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.instr_in = mk_ldi(3'(i), 8'h10 + 8'(i));
      n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready cyc %0d got %b want 1", i, bus.instr_ready); end
      if (i > 0) begin
        n_tests++; if (retire !== 1'b1) begin n_fail++; $display("FAIL b2b_retire cyc %0d got %b want 1", i, retire); end
        sb_pop(e, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_sb cyc %0d got empty want entry", i); end
        else begin
          read_reg(e.rd, v);
          n_tests++; if (v !== e.val) begin n_fail++; $display("FAIL b2b_reg R%0d got %h want %h", e.rd, v, e.val); end
        end
      end
      mregs[i] = 8'h10 + 8'(i);
      sb.push_back('{rd: 3'(i), val: mregs[i], c: mc, z: mz});
      tick();
    end
    bus.instr_valid = 1'b0;
    n_tests++; if (retire !== 1'b1) begin n_fail++; $display("FAIL b2b_retire_last got %b want 1", retire); end
    sb_pop(e, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_sb_last got empty want entry"); end
    tick();
    n_tests++; if (retire !== 1'b0) begin n_fail++; $display("FAIL b2b_retire_end got %b want 0", retire); end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      n_tests++; if (v !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL b2b_readback R%0d got %h want %h", i, v, 8'h10 + 8'(i)); end
    end
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_compare_and_logic();
    test_mult_stall();
    test_nop();
    test_illegal();
    test_reset_mid_exec();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream feeder for the core's ALU: accepts 16-bit instructions over a valid/ready handshake, reads operands from an 8x8 register file, and drives the packed 20-bit ALU opcode vector.
- Holds the vector stable for the op's latency, then captures result, carry and zero into the register file and flag registers.
- One instruction in flight at a time; one instance per core.

Parameters:
- DATA_WIDTH, 8, operand/result width
- OPCODE_LENGTH, 4, opcode field width
- REG_ADDR_W, 3, register address width (8 registers)
- ALU_LATENCY, 2, cycles from vector drive to valid result for all ops except MULT/DIVIDE (must be at least 1)
- MULDIV_LATENCY, 6, same, for MULT/DIVIDE (must be at least 1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_in  in  1  asynchronous, active-high reset
- instr_in  in  16  instruction: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2; for LDI, [7:0] is the immediate
- instr_valid  in  1  instruction present
- instr_ready  out  1  stage can accept
- opcode_inputs  out  20  {opcode, operand A, operand B} to ALU
- final_output  in  8  ALU result
- carry_output  in  1  ALU carry
- zero_flag  in  1  ALU zero
- flag_carry  out  1  registered carry flag
- flag_zero  out  1  registered zero flag
- retire  out  1  one-cycle pulse per completed instruction
- illegal_op  out  1  one-cycle pulse on illegal opcode accept
- dbg_addr  in  3  debug register select
- dbg_data  out  8  combinational read of register dbg_addr

Behaviour:
- Opcodes:
  - 0000 NOP
  - 0001 ADD, 0010 SUB, 0011 MULT, 0100 DIVIDE, 0110 AND, 0111 OR: write rd and flags
  - 1001 ZERO TEST, 1010 GT, 1011 EQ, 1100 LT: write flags only; rd untouched
  - 1111 LDI
  - 0101, 1000, 1101, 1110 illegal
- Reset (async):
  - State = IDLE; all registers = 0; flag_carry, flag_zero = 0; opcode_inputs = 0.
  - retire = 0, illegal_op = 0, instr_ready = 0 while reset_in high.
- State machine: IDLE, EXEC.
- IDLE:
  - instr_ready = 1. Accept occurs when instr_valid and instr_ready are both high on a clock edge.
  - LDI: rd <= imm on the accept edge; retire pulses next cycle; stays IDLE. Back-to-back LDIs sustain one per cycle.
  - NOP: consumed; retire pulses; no state change.
  - Illegal: consumed; illegal_op pulses; no retire; no register or flag change.
  - ALU op: on the accept edge, opcode_inputs <= {opcode, R[rs1], R[rs2]}. Counter <= latency-1, using MULDIV_LATENCY for MULT/DIVIDE and ALU_LATENCY otherwise. Go to EXEC.
- EXEC:
  - instr_ready = 0; opcode_inputs held constant.
  - Counter decrements each cycle.
  - On the edge where counter == 0: sample final_output, carry_output, zero_flag. Write rd if the op writes rd; update both flags; pulse retire the following cycle; return to IDLE.
  - Accept-to-retire = latency+1 cycles.
- After return to IDLE, opcode_inputs keeps its last value (no spurious ALU activity).
- rd equal to rs1/rs2 is legal; operands are read at accept, so there is no hazard.
- Reset asserted mid-EXEC aborts with no writeback; the counter is cleared.
- Register arithmetic is modulo 2^8; this stage performs no arithmetic.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- When defined:
  - Adds output port perf_retired[15:0], counting retire pulses; wraps 0xFFFF to 0x0000; reset to 0.
  - Adds output port perf_busy[15:0], counting cycles in EXEC; saturates at 0xFFFF.
- When undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_NOP, OP_ADD, ... OP_LDI)
  - VECTOR_LENGTH = OPCODE_LENGTH + 2*DATA_WIDTH
  - state encoding IDLE/EXEC
  - is_muldiv, writes_rd and is_illegal decode functions
- One sub-module, alu_regfile:
  - 8x8 register file, 2 combinational read ports plus debug read port, 1 synchronous write port
  - asynchronous clear on reset_in

Test Plan:
1. LDI R1=0xFF, LDI R2=0x01, ADD R3,R1,R2 with ALU model returning 0x00/carry 1/zero 1 -> opcode_inputs=20'h1FF01 throughout EXEC; R3=0x00, flag_carry=1, flag_zero=1; retire 3 cycles after ADD accept (ALU_LATENCY=2).
2. LDI R4=0x05, LDI R5=0x09, LT R4,R5 with ALU returning 0x01/carry 0/zero 0 -> opcode_inputs=20'hC0509; flags updated; R4 still 0x05 via dbg_data.
3. MULT R6,R1,R2 -> instr_ready low exactly 6 cycles; an instr_valid held during EXEC is not accepted until IDLE; retire 7 cycles after accept.
4. Illegal opcode 0101 -> illegal_op pulses once; instr_ready stays 1; no retire; registers and flags unchanged.
5. Reset pulse 2 cycles into a MULT EXEC -> immediate IDLE, all registers and flags 0, opcode_inputs=0, no retire; a following LDI R1=0xAA is accepted normally.
6. Eight back-to-back LDIs R0..R7=0x10..0x17 with instr_valid held high -> one accept per cycle, eight retire pulses, dbg_data reads back all values.
